// File: rtl/pump_pkg.sv
// Shared types and default key codes for the harpoon (pump) block and its neighbours.
package pump_pkg;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  typedef enum logic [1:0] {IDLE, EXTEND, HOLD, RETRACT} pump_state_t;

  localparam logic [7:0] KEY_FIRE_DEF  = 8'd44;
  localparam logic [7:0] KEY_UP_DEF    = 8'd26;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'd22;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'd7;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'd4;

endpackage

// File: rtl/pump_ctrl_if.sv
// Signal bundle between the game logic and the harpoon controller, plus FSM debug taps.
interface pump_ctrl_if;
  import pump_pkg::*;

  // No valid/ready handshake: frame_clk is a free-running strobe sampled
  // through a synchroniser, all other inputs are level signals read every cycle,
  // and inflate_pulse is a one-Clk event with no back-pressure.
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [7:0]  last_key_press;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  Ball_X_Loc;
  logic [9:0]  Ball_Y_Loc;
  logic        enemy_hit;
  logic        pump_active;
  logic [9:0]  pump_tip_x;
  logic [9:0]  pump_tip_y;
  logic        inflate_pulse;
  logic        is_pump;
  pump_state_t dbg_state;
  logic [7:0]  dbg_len;

  modport master (
    output frame_clk, keycode, last_key_press, DrawX, DrawY,
           Ball_X_Loc, Ball_Y_Loc, enemy_hit,
    input  pump_active, pump_tip_x, pump_tip_y, inflate_pulse, is_pump,
           dbg_state, dbg_len
  );

  modport slave (
    input  frame_clk, keycode, last_key_press, DrawX, DrawY,
           Ball_X_Loc, Ball_Y_Loc, enemy_hit,
    output pump_active, pump_tip_x, pump_tip_y, inflate_pulse, is_pump,
           dbg_state, dbg_len
  );

endinterface

// File: rtl/pump_ctrl_frame_tick_sync.sv
// Brings the asynchronous frame strobe into the clk domain and emits a one-cycle tick on its rising edge.
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= strobe;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/pump_ctrl.sv
// Frame-stepped harpoon: extends from the player, latches on an enemy, emits inflate pulses, retracts.
module pump_ctrl
  import pump_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         STEP        = 2,
  parameter int         OFFSET      = 8,
  parameter int         HALF_W      = 4,
  parameter int         SCREEN_W    = 512,
  parameter int         SCREEN_H    = 480,
  parameter int         HOLD_FRAMES = 30,
  parameter logic [7:0] KEY_FIRE    = KEY_FIRE_DEF,
  parameter logic [7:0] KEY_UP      = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN    = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_RIGHT   = KEY_RIGHT_DEF,
  parameter logic [7:0] KEY_LEFT    = KEY_LEFT_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  pump_ctrl_if.slave  bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [10:0] OFF_S   = 11'(OFFSET);
  localparam logic signed [10:0] HALF_S  = 11'(HALF_W);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] MAX_S   = 11'(MAX_LEN);
  localparam logic signed [10:0] XMAX_S  = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] YMAX_S  = 11'(SCREEN_H - 1);
  localparam logic [LW-1:0]      STEP_L  = LW'(STEP);
  localparam logic [LW-1:0]      MAX_L   = LW'(MAX_LEN);
  localparam logic [HW-1:0]      HOLD_END = HW'(HOLD_FRAMES - 1);

  logic tick;

  frame_tick_sync u_tick (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .strobe (bus.frame_clk),
    .tick   (tick)
  );

  pump_state_t   state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [LW-1:0] len_q, len_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          fire_prev_q;
  logic          pulse_q, pulse_d;

  logic fire;
  logic fire_edge;
  assign fire      = (bus.keycode == KEY_FIRE);
  assign fire_edge = fire & ~fire_prev_q;

  logic key_valid;
  dir_t key_dir;
  dir_t cur_dir;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = UP;
    case (bus.last_key_press)
      KEY_UP:    key_dir = UP;
      KEY_DOWN:  key_dir = DOWN;
      KEY_LEFT:  key_dir = LEFT;
      KEY_RIGHT: key_dir = RIGHT;
      default:   key_valid = 1'b0;
    endcase
  end

  // While idle the room is evaluated for the candidate key direction, afterwards for the latched one.
  assign cur_dir = (state_q == IDLE) ? key_dir : dir_q;

  logic signed [10:0] x_s, y_s, dx_s, dy_s, len_s;
  assign x_s   = $signed({1'b0, bus.Ball_X_Loc});
  assign y_s   = $signed({1'b0, bus.Ball_Y_Loc});
  assign dx_s  = $signed({1'b0, bus.DrawX});
  assign dy_s  = $signed({1'b0, bus.DrawY});
  assign len_s = $signed({{(11-LW){1'b0}}, len_q});

  logic signed [10:0] lim;
  logic [LW-1:0]      max_len;

  always_comb begin
    case (cur_dir)
      UP:      lim = y_s - OFF_S;
      DOWN:    lim = YMAX_S - y_s - OFF_S;
      LEFT:    lim = x_s - OFF_S;
      default: lim = XMAX_S - x_s - OFF_S;
    endcase
    if (lim < 11'sd0)
      max_len = '0;
    else if (lim > MAX_S)
      max_len = MAX_L;
    else
      max_len = lim[LW-1:0];
  end

  logic [LW-1:0] len_c;
  logic [LW:0]   len_inc;
  logic [LW-1:0] len_ext;
  logic [LW-1:0] len_dec;
  logic [HW-1:0] hold_inc;

  // len_c is the player-movement clamp, applied on every tick before stepping.
  assign len_c    = (len_q > max_len) ? max_len : len_q;
  assign len_inc  = {1'b0, len_c} + {1'b0, STEP_L};
  assign len_ext  = (len_inc > {1'b0, max_len}) ? max_len : len_inc[LW-1:0];
  assign len_dec  = (len_c > STEP_L) ? (len_c - STEP_L) : '0;
  assign hold_inc = hold_q + 1'b1;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    len_d   = len_q;
    hold_d  = hold_q;
    pulse_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (fire && key_valid && (lim >= STEP_S)) begin
            dir_d   = key_dir;
            len_d   = STEP_L;
            state_d = EXTEND;
          end
        end
        EXTEND: begin
          if (bus.enemy_hit) begin
            len_d   = len_c;
            hold_d  = '0;
            state_d = HOLD;
          end else if (!fire) begin
            len_d   = len_c;
            state_d = RETRACT;
          end else begin
            len_d = len_ext;
            if (len_ext == max_len)
              state_d = RETRACT;
          end
        end
        HOLD: begin
          len_d = len_c;
          if (!bus.enemy_hit) begin
            state_d = RETRACT;
          end else if (fire_edge) begin
            pulse_d = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_END)
              state_d = RETRACT;
          end
        end
        default: begin
          len_d = len_dec;
          if (len_dec == '0)
            state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      dir_q       <= UP;
      len_q       <= '0;
      hold_q      <= '0;
      fire_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
      if (tick)
        fire_prev_q <= fire;
    end
  end

  logic in_along;
  logic in_across;

  always_comb begin
    case (dir_q)
      UP: begin
        in_along  = (dy_s >= y_s - OFF_S - len_s) && (dy_s <= y_s - OFF_S - 11'sd1);
        in_across = (dx_s >= x_s - HALF_S) && (dx_s <= x_s + HALF_S);
      end
      DOWN: begin
        in_along  = (dy_s >= y_s + OFF_S + 11'sd1) && (dy_s <= y_s + OFF_S + len_s);
        in_across = (dx_s >= x_s - HALF_S) && (dx_s <= x_s + HALF_S);
      end
      LEFT: begin
        in_along  = (dx_s >= x_s - OFF_S - len_s) && (dx_s <= x_s - OFF_S - 11'sd1);
        in_across = (dy_s >= y_s - HALF_S) && (dy_s <= y_s + HALF_S);
      end
      default: begin
        in_along  = (dx_s >= x_s + OFF_S + 11'sd1) && (dx_s <= x_s + OFF_S + len_s);
        in_across = (dy_s >= y_s - HALF_S) && (dy_s <= y_s + HALF_S);
      end
    endcase
  end

  logic [9:0] reach;
  assign reach = 10'(OFFSET) + 10'(len_q);

  always_comb begin
    bus.pump_tip_x = bus.Ball_X_Loc;
    bus.pump_tip_y = bus.Ball_Y_Loc;
    if (len_q != '0) begin
      case (dir_q)
        UP:      bus.pump_tip_y = bus.Ball_Y_Loc - reach;
        DOWN:    bus.pump_tip_y = bus.Ball_Y_Loc + reach;
        LEFT:    bus.pump_tip_x = bus.Ball_X_Loc - reach;
        default: bus.pump_tip_x = bus.Ball_X_Loc + reach;
      endcase
    end
  end

  assign bus.is_pump       = (state_q != IDLE) && (len_q != '0) && in_along && in_across;
  assign bus.pump_active   = (state_q != IDLE);
  assign bus.inflate_pulse = pulse_q;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_len       = 8'(len_q);

endmodule
